// File: rtl/instr_buffer.sv
// -----------------------------------------------------------------------------
// instr_buffer
//   Circular FIFO between the fetch stage and decode. Fetch pushes fetched
//   instruction words with their PC, predicted-taken bit and early-decode
//   register-use flags. Decode pops the head entry when it advances. A branch
//   flush empties the buffer in one cycle.
//
// Ports
//   clk              clock
//   rst_n            synchronous active-low reset
//   push             write in_* into the tail entry
//   flush            discard all entries (branch mispredict)
//   in_instruction   fetched instruction word (32)
//   in_pc            instruction PC (32)
//   in_prediction    branch predicted taken
//   in_uses_rs1/rs2/rd  early-decode register-use flags
//   pop              decode advance; consumes the head when valid
//   valid            buffer not empty; out_* meaningful
//   out_*            head entry fields (combinational from storage)
//   full             count == DEPTH
//   early_full       count >= DEPTH-1
//   overflow         sticky: a push was dropped because the buffer was full
// -----------------------------------------------------------------------------
module instr_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        flush,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_pc,
    input  logic        in_prediction,
    input  logic        in_uses_rs1,
    input  logic        in_uses_rs2,
    input  logic        in_uses_rd,
    input  logic        pop,
    output logic        valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        out_prediction,
    output logic        out_uses_rs1,
    output logic        out_uses_rs2,
    output logic        out_uses_rd,
    output logic        full,
    output logic        early_full,
    output logic        overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 68;

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_EARLY  = CNT_W'(DEPTH - 1);

    // Entry layout: {instruction, pc, prediction, uses_rs1, uses_rs2, uses_rd}
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             early_full_q, early_full_d;
    logic             overflow_q, overflow_d;

    logic             pop_ok;
    logic             push_ok;
    logic             write_en;
    logic [ENTRY_W-1:0] head;

    // A push into a full buffer is still accepted when the head leaves in the
    // same cycle: the new entry takes the freed slot.
    assign pop_ok  = pop & valid_q;
    assign push_ok = push & (~full_q | pop_ok);

    // Storage is only written on an accepted push outside reset and flush.
    assign write_en = rst_n & ~flush & push_ok;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (push & full_q & ~pop_ok) begin
                overflow_d = 1'b1;
            end
        end

        // Status flags are registered from the next count so they never
        // depend combinationally on push/pop.
        valid_d      = (count_d != '0);
        full_d       = (count_d == CNT_FULL);
        early_full_d = (count_d >= CNT_EARLY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            full_q       <= 1'b0;
            early_full_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            full_q       <= full_d;
            early_full_q <= early_full_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= {in_instruction, in_pc, in_prediction,
                                in_uses_rs1, in_uses_rs2, in_uses_rd};
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign out_instruction = head[67:36];
    assign out_pc          = head[35:4];
    assign out_prediction  = head[3];
    assign out_uses_rs1    = head[2];
    assign out_uses_rs2    = head[1];
    assign out_uses_rd     = head[0];

    assign valid      = valid_q;
    assign full       = full_q;
    assign early_full = early_full_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_instr_buffer.sv
module tb_instr_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        push = 1'b0;
    logic        flush = 1'b0;
    logic        pop = 1'b0;
    logic [31:0] in_instruction = '0;
    logic [31:0] in_pc = '0;
    logic        in_prediction = 1'b0;
    logic        in_uses_rs1 = 1'b0;
    logic        in_uses_rs2 = 1'b0;
    logic        in_uses_rd = 1'b0;
    logic        valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_prediction;
    logic        out_uses_rs1;
    logic        out_uses_rs2;
    logic        out_uses_rd;
    logic        full;
    logic        early_full;
    logic        overflow;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: an ordered list of buffered entries plus a sticky flag.
    logic [67:0] mq[$];
    bit          movf = 1'b0;

    instr_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .flush(flush),
        .in_instruction(in_instruction), .in_pc(in_pc),
        .in_prediction(in_prediction), .in_uses_rs1(in_uses_rs1),
        .in_uses_rs2(in_uses_rs2), .in_uses_rd(in_uses_rd),
        .pop(pop), .valid(valid),
        .out_instruction(out_instruction), .out_pc(out_pc),
        .out_prediction(out_prediction), .out_uses_rs1(out_uses_rs1),
        .out_uses_rs2(out_uses_rs2), .out_uses_rd(out_uses_rd),
        .full(full), .early_full(early_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [67:0] head_entry();
        return {out_instruction, out_pc, out_prediction,
                out_uses_rs1, out_uses_rs2, out_uses_rd};
    endfunction

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic step(input bit p, input bit po, input bit fl, input bit rn,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [3:0] flg);
        bit pop_ok, push_ok;
        push = p; pop = po; flush = fl; rst_n = rn;
        in_instruction = ins; in_pc = pc;
        {in_prediction, in_uses_rs1, in_uses_rs2, in_uses_rd} = flg;
        @(posedge clk);
        #1;
        if (!rn) begin
            mq.delete();
            movf = 1'b0;
        end else if (fl) begin
            mq.delete();
        end else begin
            pop_ok  = po && (mq.size() != 0);
            push_ok = p && ((mq.size() < DEPTH) || pop_ok);
            if (p && !push_ok) movf = 1'b1;
            if (pop_ok) mq.delete(0);
            if (push_ok) mq.push_back({ins, pc, flg});
        end
        push = 0; pop = 0; flush = 0; rst_n = 1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 1, 32'h13 + 32'(i) * 4, 32'h100 + 32'(i) * 4, 4'(i));
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({valid, full, early_full, overflow} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 0000", {valid, full, early_full, overflow});
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] instrs [4];
        instrs = '{32'h13, 32'h17, 32'h33, 32'h37};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, instrs[i], 32'h100 + 32'(i) * 4, 4'h0);
            tests_run++;
            if (valid !== 1'b1 || early_full !== (i >= 2) || full !== (i == 3) || out_pc !== 32'h100) begin
                tests_failed++;
                $display("FAIL fill_%0d: got v=%b ef=%b f=%b pc=%h expected v=1 ef=%b f=%b pc=00000100",
                         i, valid, early_full, full, out_pc, (i >= 2), (i == 3));
            end
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_pc !== 32'h100 + 32'(i) * 4 || out_instruction !== instrs[i]) begin
                tests_failed++;
                $display("FAIL drain_%0d: got pc=%h ins=%h expected pc=%h ins=%h",
                         i, out_pc, out_instruction, 32'h100 + 32'(i) * 4, instrs[i]);
            end
            step(0, 1, 0, 1, 32'h0, 32'h0, 4'h0);
        end
        tests_run++;
        if (valid !== 1'b0 || full !== 1'b0 || early_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_empty: got v=%b f=%b ef=%b expected 0 0 0", valid, full, early_full);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] last_pc;
        do_reset();
        fill4();
        step(1, 1, 0, 1, 32'hABCD, 32'h200, 4'hF);
        tests_run++;
        if (full !== 1'b1 || overflow !== 1'b0 || valid !== 1'b1 || out_pc !== 32'h104) begin
            tests_failed++;
            $display("FAIL full_pushpop: got f=%b ovf=%b v=%b pc=%h expected 1 0 1 00000104",
                     full, overflow, valid, out_pc);
        end
        last_pc = '0;
        for (int i = 0; i < 4; i++) begin
            last_pc = out_pc;
            step(0, 1, 0, 1, 32'h0, 32'h0, 4'h0);
        end
        tests_run++;
        if (last_pc !== 32'h200 || valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_pushpop_last: got pc=%h v=%b expected 00000200 0", last_pc, valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fill4();
        step(1, 0, 0, 1, 32'hDEAD, 32'h999, 4'h0);
        tests_run++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_set: got ovf=%b f=%b expected 1 1", overflow, full);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_pc !== 32'h100 + 32'(i) * 4) begin
                tests_failed++;
                $display("FAIL overflow_contents_%0d: got %h expected %h", i, out_pc, 32'h100 + 32'(i) * 4);
            end
            step(0, 1, 0, 1, 32'h0, 32'h0, 4'h0);
        end
        tests_run++;
        if (valid !== 1'b0 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_sticky: got v=%b ovf=%b expected 0 1", valid, overflow);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 32'h1, 32'h100 + 32'(i) * 4, 4'h0);
        step(1, 1, 1, 1, 32'h2, 32'h500, 4'h0);
        tests_run++;
        if ({valid, full, early_full, overflow} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL flush_state: got %b expected 0000", {valid, full, early_full, overflow});
        end
        step(1, 0, 0, 1, 32'h3, 32'h300, 4'hA);
        tests_run++;
        if (valid !== 1'b1 || out_pc !== 32'h300 || early_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_push: got v=%b pc=%h ef=%b expected 1 00000300 0", valid, out_pc, early_full);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pc;
        do_reset();
        step(1, 0, 0, 1, $urandom, 32'h1000, 4'($urandom));
        for (int i = 0; i < 10; i++) begin
            pc = 32'h1004 + 32'(i) * 4;
            step(1, 0, 0, 1, $urandom, pc, 4'($urandom));
            tests_run++;
            if (head_entry() !== mq[0]) begin
                tests_failed++;
                $display("FAIL wrap_%0d: got %h expected %h", i, head_entry(), mq[0]);
            end
            step(0, 1, 0, 1, 32'h0, 32'h0, 4'h0);
        end
        tests_run++;
        if (valid !== 1'b1 || head_entry() !== mq[0] || out_pc !== 32'h1028) begin
            tests_failed++;
            $display("FAIL wrap_tail: got v=%b pc=%h expected 1 00001028", valid, out_pc);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        fill4();
        step(1, 0, 0, 1, 32'h0, 32'h777, 4'h0);
        step(0, 1, 0, 1, 32'h0, 32'h0, 4'h0);
        step(0, 1, 0, 1, 32'h0, 32'h0, 4'h0);
        tests_run++;
        if (valid !== 1'b1 || overflow !== 1'b1 || early_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL midstream_pre: got v=%b ovf=%b ef=%b expected 1 1 0", valid, overflow, early_full);
        end
        step(1, 1, 0, 0, 32'h5, 32'h555, 4'h0);
        tests_run++;
        if ({valid, full, early_full, overflow} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midstream_reset: got %b expected 0000", {valid, full, early_full, overflow});
        end
        step(0, 1, 0, 1, 32'h0, 32'h0, 4'h0);
        tests_run++;
        if ({valid, full, early_full, overflow} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL empty_pop: got %b expected 0000", {valid, full, early_full, overflow});
        end
        step(1, 0, 0, 1, 32'h9, 32'h900, 4'h5);
        step(0, 1, 0, 1, 32'h0, 32'h0, 4'h0);
        tests_run++;
        if (valid !== 1'b0 || early_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_underflow: got v=%b ef=%b expected 0 0", valid, early_full);
        end
    endtask

    task automatic test_random();
        bit p, po, fl, rn;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            p  = ($urandom_range(0, 99) < 65);
            po = ($urandom_range(0, 99) < 50);
            fl = ($urandom_range(0, 99) < 3);
            rn = ($urandom_range(0, 199) != 0);
            step(p, po, fl, rn, $urandom, $urandom, 4'($urandom));
            tests_run++;
            if (valid !== (mq.size() != 0) || full !== (mq.size() == DEPTH) ||
                early_full !== (mq.size() >= DEPTH - 1) || overflow !== movf) begin
                tests_failed++;
                $display("FAIL random_flags_%0d: got v=%b f=%b ef=%b ovf=%b expected count=%0d ovf=%b",
                         i, valid, full, early_full, overflow, mq.size(), movf);
            end
            if (mq.size() != 0) begin
                tests_run++;
                if (head_entry() !== mq[0]) begin
                    tests_failed++;
                    $display("FAIL random_head_%0d: got %h expected %h", i, head_entry(), mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_overflow();
        test_flush();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
